mem_arbiter: RTL and testbench

- Shares one data-memory port between the instruction-fetch requester and the load/store requester of the pipeline.
- The arbiter owns the single memory request/response port. It holds one transaction in flight at a time and returns each response to the requester that issued it.
- Fair round-robin grants; a response timeout guarantees that a silent memory cannot hang the pipeline.

---
 rtl/mem_arbiter.sv | 98 +++++++++
 tb/tb_mem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one memory port between fetch and load/store, with response timeout
module mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int WORD_W = 32,
  parameter int COUNT_W = 2,
  parameter int CODE_W = 2,
  parameter int TIMEOUT = 16,
  parameter logic [CODE_W-1:0] TIMEOUT_CODE = 2'b11
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               i_instr_req_valid,
  input  logic [ADDR_W-1:0]  i_instr_req_addr,
  output logic               o_instr_req_ready,
  output logic               o_instr_res_valid,
  output logic [WORD_W-1:0]  o_instr_res_data,
  output logic [CODE_W-1:0]  o_instr_res_code,
  input  logic               i_data_req_valid,
  input  logic [ADDR_W-1:0]  i_data_req_addr,
  input  logic [WORD_W-1:0]  i_data_req_wr_data,
  input  logic               i_data_req_wr_en,
  input  logic [COUNT_W-1:0] i_data_req_count,
  output logic               o_data_req_ready,
  output logic               o_data_res_valid,
  output logic [WORD_W-1:0]  o_data_res_data,
  output logic [CODE_W-1:0]  o_data_res_code,
  output logic               o_mem_req_valid,
  output logic [ADDR_W-1:0]  o_mem_req_addr,
  output logic [WORD_W-1:0]  o_mem_req_wr_data,
  output logic               o_mem_req_wr_en,
  output logic [COUNT_W-1:0] o_mem_req_count,
  input  logic               i_mem_res_valid,
  input  logic [WORD_W-1:0]  i_mem_res_rd_data,
  input  logic [CODE_W-1:0]  i_mem_res_code
);
  localparam int TW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0] LAST = TW'(TIMEOUT > 0 ? TIMEOUT - 1 : 0);
  typedef enum logic {IDLE, BUSY} state_t;
  state_t state, state_nx;
  logic prio_data, owner_data, grant_data, accept, timed_out, done;
  logic [TW-1:0] cnt;
  // grant arbitration, completion detection and next state
  always_comb begin
    grant_data = i_data_req_valid && (!i_instr_req_valid || prio_data);
    o_data_req_ready = state == IDLE && grant_data;
    o_instr_req_ready = state == IDLE && i_instr_req_valid && !grant_data;
    accept = o_data_req_ready || o_instr_req_ready;
    timed_out = TIMEOUT != 0 && cnt == LAST && !i_mem_res_valid;
    done = state == BUSY && (i_mem_res_valid || timed_out);
    state_nx = accept ? BUSY : done ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk or posedge areset)
    if (areset) state <= IDLE;
    else state <= state_nx;
  // request latching, timeout counting and response routing
  always_ff @(posedge clk or posedge areset)
    if (areset) begin
      prio_data <= 1'b1;
      owner_data <= 1'b0;
      cnt <= '0;
      o_mem_req_valid <= 1'b0;
      o_mem_req_addr <= '0;
      o_mem_req_wr_data <= '0;
      o_mem_req_wr_en <= 1'b0;
      o_mem_req_count <= '0;
      o_instr_res_valid <= 1'b0;
      o_instr_res_data <= '0;
      o_instr_res_code <= '0;
      o_data_res_valid <= 1'b0;
      o_data_res_data <= '0;
      o_data_res_code <= '0;
    end else begin
      o_instr_res_valid <= 1'b0;
      o_data_res_valid <= 1'b0;
      if (accept) begin
        prio_data <= !grant_data;
        owner_data <= grant_data;
        cnt <= '0;
        o_mem_req_valid <= 1'b1;
        o_mem_req_addr <= grant_data ? i_data_req_addr : i_instr_req_addr;
        o_mem_req_wr_data <= grant_data ? i_data_req_wr_data : '0;
        o_mem_req_wr_en <= grant_data && i_data_req_wr_en;
        o_mem_req_count <= grant_data ? i_data_req_count : '1;
      end else if (done) begin
        o_mem_req_valid <= 1'b0;
        if (owner_data) begin
          o_data_res_valid <= 1'b1;
          o_data_res_data <= i_mem_res_valid ? i_mem_res_rd_data : '0;
          o_data_res_code <= i_mem_res_valid ? i_mem_res_code : TIMEOUT_CODE;
        end else begin
          o_instr_res_valid <= 1'b1;
          o_instr_res_data <= i_mem_res_valid ? i_mem_res_rd_data : '0;
          o_instr_res_code <= i_mem_res_valid ? i_mem_res_code : TIMEOUT_CODE;
        end
      end else if (state == BUSY) cnt <= cnt + TW'(1);
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed stimulus checked against a transaction-level model of the arbiter
module tb_mem_arbiter;
  localparam int TO = 4;
  logic clk = 0, areset;
  logic i_instr_req_valid, o_instr_req_ready, o_instr_res_valid;
  logic [31:0] i_instr_req_addr, o_instr_res_data;
  logic [1:0] o_instr_res_code;
  logic i_data_req_valid, i_data_req_wr_en, o_data_req_ready, o_data_res_valid;
  logic [31:0] i_data_req_addr, i_data_req_wr_data, o_data_res_data;
  logic [1:0] i_data_req_count, o_data_res_code;
  logic o_mem_req_valid, o_mem_req_wr_en, i_mem_res_valid;
  logic [31:0] o_mem_req_addr, o_mem_req_wr_data, i_mem_res_rd_data;
  logic [1:0] o_mem_req_count, i_mem_res_code;
  int errors = 0, checks = 0;
  bit glog[$];

  mem_arbiter #(.TIMEOUT(TO)) dut (
    .clk(clk), .areset(areset),
    .i_instr_req_valid(i_instr_req_valid), .i_instr_req_addr(i_instr_req_addr),
    .o_instr_req_ready(o_instr_req_ready), .o_instr_res_valid(o_instr_res_valid),
    .o_instr_res_data(o_instr_res_data), .o_instr_res_code(o_instr_res_code),
    .i_data_req_valid(i_data_req_valid), .i_data_req_addr(i_data_req_addr),
    .i_data_req_wr_data(i_data_req_wr_data), .i_data_req_wr_en(i_data_req_wr_en),
    .i_data_req_count(i_data_req_count), .o_data_req_ready(o_data_req_ready),
    .o_data_res_valid(o_data_res_valid), .o_data_res_data(o_data_res_data),
    .o_data_res_code(o_data_res_code), .o_mem_req_valid(o_mem_req_valid),
    .o_mem_req_addr(o_mem_req_addr), .o_mem_req_wr_data(o_mem_req_wr_data),
    .o_mem_req_wr_en(o_mem_req_wr_en), .o_mem_req_count(o_mem_req_count),
    .i_mem_res_valid(i_mem_res_valid), .i_mem_res_rd_data(i_mem_res_rd_data),
    .i_mem_res_code(i_mem_res_code)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [63:0] a, input logic [63:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", n, a, e);
    end
  endtask

  // Model: one outstanding transaction, an absolute deadline edge, and a priority flag
  bit m_busy, m_prio_data, m_own_data, m_got, m_we;
  int m_cyc, m_due;
  logic [31:0] m_addr, m_wd, m_ir_d, m_dr_d;
  logic [1:0] m_cnt, m_ir_c, m_dr_c;
  logic m_ir_v, m_dr_v;

  function automatic bit pick_data();
    return i_data_req_valid && (!i_instr_req_valid || m_prio_data);
  endfunction

  always @(posedge clk or posedge areset)
    if (areset) begin
      m_busy = 0; m_prio_data = 1; m_cyc = 0; m_ir_v = 0; m_dr_v = 0;
      m_ir_d = 0; m_dr_d = 0; m_ir_c = 0; m_dr_c = 0;
    end else begin
      m_cyc++;
      m_ir_v = 0; m_dr_v = 0;
      if (m_busy) begin
        m_got = i_mem_res_valid;
        if (m_got || m_cyc == m_due) begin
          m_busy = 0;
          if (m_own_data) begin
            m_dr_v = 1; m_dr_d = m_got ? i_mem_res_rd_data : 0; m_dr_c = m_got ? i_mem_res_code : 2'b11;
          end else begin
            m_ir_v = 1; m_ir_d = m_got ? i_mem_res_rd_data : 0; m_ir_c = m_got ? i_mem_res_code : 2'b11;
          end
        end
      end else if (i_data_req_valid || i_instr_req_valid) begin
        m_own_data = pick_data();
        m_addr = m_own_data ? i_data_req_addr : i_instr_req_addr;
        m_wd = m_own_data ? i_data_req_wr_data : 0;
        m_we = m_own_data && i_data_req_wr_en;
        m_cnt = m_own_data ? i_data_req_count : 2'b11;
        m_prio_data = !m_own_data;
        m_busy = 1;
        m_due = m_cyc + TO;
      end
    end

  always @(negedge clk)
    if (!areset) begin
      chk("instr_ready", o_instr_req_ready, !m_busy && i_instr_req_valid && !pick_data());
      chk("data_ready", o_data_req_ready, !m_busy && pick_data());
      chk("mem_valid", o_mem_req_valid, m_busy);
      if (m_busy) begin
        chk("mem_addr", o_mem_req_addr, m_addr);
        chk("mem_wr_data", o_mem_req_wr_data, m_wd);
        chk("mem_wr_en", o_mem_req_wr_en, m_we);
        chk("mem_count", o_mem_req_count, m_cnt);
      end
      chk("instr_res_valid", o_instr_res_valid, m_ir_v);
      chk("instr_res_data", o_instr_res_data, m_ir_d);
      chk("instr_res_code", o_instr_res_code, m_ir_c);
      chk("data_res_valid", o_data_res_valid, m_dr_v);
      chk("data_res_data", o_data_res_data, m_dr_d);
      chk("data_res_code", o_data_res_code, m_dr_c);
      if (o_data_req_ready) glog.push_back(1'b1);
      if (o_instr_req_ready) glog.push_back(1'b0);
    end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rsp(input logic [31:0] d, input logic [1:0] c);
    i_mem_res_valid = 1; i_mem_res_rd_data = d; i_mem_res_code = c;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    areset = 1;
    i_instr_req_valid = 0; i_instr_req_addr = 0;
    i_data_req_valid = 0; i_data_req_addr = 0; i_data_req_wr_data = 0;
    i_data_req_wr_en = 0; i_data_req_count = 0;
    i_mem_res_valid = 0; i_mem_res_rd_data = 0; i_mem_res_code = 0;
    #3;
    chk("rst_mem_valid", o_mem_req_valid, 0);
    chk("rst_mem_addr", o_mem_req_addr, 0);
    chk("rst_instr_res_valid", o_instr_res_valid, 0);
    chk("rst_data_res_code", o_data_res_code, 0);
    step; step; areset = 0;
    // single fetch
    i_instr_req_valid = 1; i_instr_req_addr = 32'h10;
    @(negedge clk); chk("fetch_ready", o_instr_req_ready, 1);
    step; i_instr_req_valid = 0;
    @(negedge clk);
    chk("fetch_mem_addr", o_mem_req_addr, 32'h10);
    chk("fetch_mem_count", o_mem_req_count, 3);
    chk("fetch_mem_wr_en", o_mem_req_wr_en, 0);
    step; rsp(32'hDEADBEEF, 0);
    step; i_mem_res_valid = 0;
    @(negedge clk);
    chk("fetch_res_valid", o_instr_res_valid, 1);
    chk("fetch_res_data", o_instr_res_data, 32'hDEADBEEF);
    chk("fetch_data_res_quiet", o_data_res_valid, 0);
    // simultaneous requests after reset
    step; areset = 1; step; areset = 0;
    glog.delete();
    i_data_req_valid = 1; i_data_req_addr = 32'h100; i_data_req_count = 3;
    i_instr_req_valid = 1; i_instr_req_addr = 32'h20;
    step; i_data_req_addr = 32'h104; rsp(32'hAAAA0001, 0);
    step; i_mem_res_valid = 0;
    @(negedge clk);
    chk("rr1_data_res", o_data_res_data, 32'hAAAA0001);
    chk("rr1_instr_quiet", o_instr_res_valid, 0);
    chk("rr2_instr_ready", o_instr_req_ready, 1);
    step; rsp(32'hBBBB0002, 1);
    step; i_mem_res_valid = 0;
    @(negedge clk);
    chk("rr2_instr_res", o_instr_res_data, 32'hBBBB0002);
    chk("rr2_instr_code", o_instr_res_code, 1);
    chk("rr2_data_quiet", o_data_res_valid, 0);
    chk("rr3_data_ready", o_data_req_ready, 1);
    step; i_data_req_valid = 0; i_instr_req_valid = 0; rsp(32'hCCCC0003, 2);
    step; i_mem_res_valid = 0;
    @(negedge clk);
    chk("rr3_data_res", o_data_res_data, 32'hCCCC0003);
    chk("rr3_instr_kept", o_instr_res_data, 32'hBBBB0002);
    chk("grant_count", glog.size(), 3);
    if (glog.size() == 3) begin
      chk("grant0_data", glog[0], 1);
      chk("grant1_instr", glog[1], 0);
      chk("grant2_data", glog[2], 1);
    end
    // store
    step;
    i_data_req_valid = 1; i_data_req_addr = 32'h8; i_data_req_wr_data = 32'h12345678;
    i_data_req_wr_en = 1; i_data_req_count = 1;
    @(negedge clk); chk("store_ready", o_data_req_ready, 1);
    step; i_data_req_valid = 0; i_data_req_wr_en = 0;
    @(negedge clk);
    chk("store_wr_en", o_mem_req_wr_en, 1);
    chk("store_wr_data", o_mem_req_wr_data, 32'h12345678);
    chk("store_count", o_mem_req_count, 1);
    step;
    step; rsp(0, 0);
    step; i_mem_res_valid = 0;
    @(negedge clk); chk("store_res_valid", o_data_res_valid, 1);
    step;
    @(negedge clk); chk("store_res_pulse_end", o_data_res_valid, 0);
    // timeout with silent memory
    step; i_data_req_valid = 1; i_data_req_addr = 32'h40; i_data_req_count = 3;
    step; i_data_req_valid = 0;
    step; step; step;
    @(negedge clk); chk("to_not_yet", o_data_res_valid, 0);
    step;
    @(negedge clk);
    chk("to_res_valid", o_data_res_valid, 1);
    chk("to_res_code", o_data_res_code, 2'b11);
    chk("to_res_data", o_data_res_data, 0);
    chk("to_mem_idle", o_mem_req_valid, 0);
    step; rsp(32'h99999999, 0);
    step; i_mem_res_valid = 0;
    @(negedge clk);
    chk("late_dropped", o_data_res_valid, 0);
    chk("late_code_kept", o_data_res_code, 2'b11);
    // response on the final timeout cycle
    step; i_data_req_valid = 1; i_data_req_addr = 32'h44;
    step; i_data_req_valid = 0;
    step; step;
    step; rsp(32'h55AA55AA, 1);
    step; i_mem_res_valid = 0;
    @(negedge clk);
    chk("edge_res_valid", o_data_res_valid, 1);
    chk("edge_res_data", o_data_res_data, 32'h55AA55AA);
    chk("edge_res_code", o_data_res_code, 1);
    // reset while busy
    step; i_instr_req_valid = 1; i_instr_req_addr = 32'h80;
    step; i_instr_req_valid = 0;
    #2; areset = 1; #1;
    chk("arst_mem_valid", o_mem_req_valid, 0);
    chk("arst_mem_addr", o_mem_req_addr, 0);
    chk("arst_data_res_data", o_data_res_data, 0);
    chk("arst_data_res_code", o_data_res_code, 0);
    step; step; areset = 0;
    i_data_req_valid = 1; i_data_req_addr = 32'h88; i_instr_req_valid = 1; i_instr_req_addr = 32'h84;
    @(negedge clk);
    chk("arst_data_first", o_data_req_ready, 1);
    chk("arst_instr_wait", o_instr_req_ready, 0);
    chk("arst_no_pulse", o_instr_res_valid, 0);
    step; i_data_req_valid = 0; i_instr_req_valid = 0; rsp(32'h11112222, 0);
    step; i_mem_res_valid = 0;
    @(negedge clk);
    chk("arst_next_res", o_data_res_data, 32'h11112222);
    chk("arst_instr_quiet", o_instr_res_valid, 0);
    step;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
